// File: rtl/gmii_xmt_pkg.sv
// +------------------------------------------------------------------+
// | gmii_xmt_pkg : shared Ethernet framing constants and TX states   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package gmii_xmt_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  localparam int DEF_MIN_FRAME_LEN = 60;
  localparam int DEF_IFG_LEN       = 12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    PAD      = 3'd4,
    FCS      = 3'd5,
    IFG      = 3'd6
  } gmii_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/gmii_xmt_crc32_d8.sv
// +------------------------------------------------------------------+
// | crc32_d8 : one-byte step of the reflected IEEE 802.3 CRC-32       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module crc32_d8
  import gmii_xmt_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  d_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_w;

  // Bits enter LSB first, matching the order the byte goes out on the wire.
  always_comb begin
    crc_w = crc_i;
    for (int b = 0; b < 8; b++) begin
      if (crc_w[0] ^ d_i[b]) begin
        crc_w = (crc_w >> 1) ^ CRC32_POLY;
      end else begin
        crc_w = crc_w >> 1;
      end
    end
    crc_o = crc_w;
  end

endmodule

`default_nettype wire

// File: rtl/gmii_xmt.sv
// +------------------------------------------------------------------+
// | gmii_xmt : byte stream to GMII TX with preamble, pad, FCS, IFG    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module gmii_xmt
  import gmii_xmt_pkg::*;
#(
  parameter int PREAMBLE_LEN  = 7,
  parameter int MIN_FRAME_LEN = DEF_MIN_FRAME_LEN,
  parameter int IFG_LEN       = DEF_IFG_LEN,
  parameter bit PAD_EN        = 1'b1
) (
  input  logic       gmii_tx_clk,
  input  logic       reset_n,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  input  logic       last_in,
  output logic       ready_out,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd,
  output logic       busy_out,
  output logic       underrun_out
);

  localparam int CNT_W   = 8;
  localparam int BCW     = $clog2(MIN_FRAME_LEN + 1);
  // The IDLE cycle before a new preamble supplies the last idle cycle of the gap.
  localparam int IFG_CYC = (IFG_LEN > 1) ? IFG_LEN - 1 : 0;

  gmii_tx_state_t   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BCW-1:0]   byte_cnt_q;
  logic [7:0]       data_q;
  logic [31:0]      crc_q;
  logic             err_q;
  logic             tx_en_q;
  logic             tx_er_q;
  logic [7:0]       txd_q;
  logic             underrun_q;

  logic [31:0]      crc_d;
  logic [BCW-1:0]   byte_cnt_d;
  logic             pad_d;
  logic [31:0]      fcs_w;
  logic [1:0]       fcs_idx_w;
  logic [7:0]       fcs_byte_w;

  crc32_d8 u_crc (
    .crc_i (crc_q),
    .d_i   (data_q),
    .crc_o (crc_d)
  );

  assign byte_cnt_d = (byte_cnt_q == BCW'(MIN_FRAME_LEN)) ? byte_cnt_q : byte_cnt_q + 1'b1;
  assign pad_d      = PAD_EN && (byte_cnt_d < BCW'(MIN_FRAME_LEN));
  assign fcs_w      = ~crc_q;
  assign fcs_idx_w  = cnt_q[1:0] - 2'd1;
  assign fcs_byte_w = 8'(fcs_w >> {fcs_idx_w, 3'b000});

  assign ready_out    = (state_q == SFD) || (state_q == DATA);
  assign busy_out     = (state_q != IDLE);
  assign gmii_tx_en   = tx_en_q;
  assign gmii_tx_er   = tx_er_q;
  assign gmii_txd     = txd_q;
  assign underrun_out = underrun_q;

  // data_q holds the byte accepted last cycle; it goes out one cycle later.
  always_ff @(posedge gmii_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      crc_q      <= CRC32_INIT;
      err_q      <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      txd_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      tx_er_q    <= 1'b0;
      underrun_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_en_q    <= 1'b0;
          txd_q      <= '0;
          cnt_q      <= '0;
          byte_cnt_q <= '0;
          if (valid_in) state_q <= PREAMBLE;
        end
        PREAMBLE: begin
          tx_en_q <= 1'b1;
          txd_q   <= PREAMBLE_BYTE;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
            cnt_q   <= '0;
            state_q <= SFD;
          end
        end
        SFD: begin
          tx_en_q <= 1'b1;
          txd_q   <= SFD_BYTE;
          crc_q   <= CRC32_INIT;
          if (valid_in) begin
            data_q     <= data_in;
            byte_cnt_q <= byte_cnt_d;
            if (last_in) state_q <= pad_d ? PAD : FCS;
            else         state_q <= DATA;
          end else begin
            err_q   <= 1'b1;
            state_q <= IFG;
          end
        end
        DATA: begin
          tx_en_q <= 1'b1;
          txd_q   <= data_q;
          crc_q   <= crc_d;
          if (valid_in) begin
            data_q     <= data_in;
            byte_cnt_q <= byte_cnt_d;
            if (last_in) state_q <= pad_d ? PAD : FCS;
          end else begin
            err_q   <= 1'b1;
            state_q <= IFG;
          end
        end
        PAD: begin
          tx_en_q    <= 1'b1;
          txd_q      <= data_q;
          crc_q      <= crc_d;
          data_q     <= '0;
          byte_cnt_q <= byte_cnt_d;
          if (byte_cnt_d == BCW'(MIN_FRAME_LEN)) state_q <= FCS;
        end
        FCS: begin
          tx_en_q <= 1'b1;
          cnt_q   <= cnt_q + 1'b1;
          // Slot 0 flushes the last data/pad byte still held in data_q.
          if (cnt_q == '0) begin
            txd_q <= data_q;
            crc_q <= crc_d;
          end else begin
            txd_q <= fcs_byte_w;
          end
          if (cnt_q == CNT_W'(4)) begin
            cnt_q   <= '0;
            state_q <= (IFG_CYC == 0) ? IDLE : IFG;
          end
        end
        IFG: begin
          tx_en_q <= 1'b0;
          txd_q   <= '0;
          if (err_q) begin
            tx_en_q    <= 1'b1;
            tx_er_q    <= 1'b1;
            underrun_q <= 1'b1;
            err_q      <= 1'b0;
            if (IFG_CYC == 0) state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(IFG_CYC - 1)) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gmii_xmt.sv
// +------------------------------------------------------------------+
// | tb_gmii_xmt : scoreboard and vector-table bench for gmii_xmt      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_gmii_xmt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic [7:0] data = 8'h00;
  wire        ready, en, er, busy, unr;
  wire  [7:0] txd;

  gmii_xmt dut (
    .gmii_tx_clk  (clk),
    .reset_n      (rst_n),
    .valid_in     (valid),
    .data_in      (data),
    .last_in      (last),
    .ready_out    (ready),
    .gmii_tx_en   (en),
    .gmii_tx_er   (er),
    .gmii_txd     (txd),
    .busy_out     (busy),
    .underrun_out (unr)
  );

  always #4 clk = ~clk;

  typedef struct packed {logic er; logic [7:0] d;} gbyte_t;
  typedef struct {int len; int stop_at; int exp_en; int exp_unr;} vec_t;

  gbyte_t     exp_q[$];
  gbyte_t     e;
  logic [7:0] frame[$];
  int checks = 0, failures = 0, cyc = 0;
  int en_cycles = 0, last_en_cycles = 0, idle_run = 0, last_gap = 0, rise_cyc = 0;
  int unr_cnt = 0, bad_ready = 0, bad_idle = 0, bad_unr = 0;
  logic [31:0] last_residue = '0;
  logic prev_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c = c_in;
    for (int b = 0; b < 8; b++) c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] frame_residue();
    logic [31:0] c = 32'hFFFFFFFF;
    logic [31:0] r;
    for (int i = 8; i < frame.size(); i++) c = crc_byte(c, frame[i]);
    for (int b = 0; b < 32; b++) r[b] = c[31-b];
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // GMII monitor: compares every transmitted byte against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (ready && !en) bad_ready++;
    if (!en && (txd != 8'h00 || er)) bad_idle++;
    if (unr !== er) bad_unr++;
    if (unr) unr_cnt++;
    if (en) begin
      if (!prev_en) begin
        last_gap = idle_run;
        rise_cyc = cyc;
        en_cycles = 0;
        frame.delete();
      end
      en_cycles++;
      frame.push_back(txd);
      idle_run = 0;
      if (exp_q.size() == 0) begin
        check("unexpected_gmii_byte", {55'd0, er, txd}, 64'h1_0000);
      end else begin
        e = exp_q.pop_front();
        check("gmii_byte", {55'd0, er, txd}, {55'd0, e});
      end
    end else begin
      if (prev_en) begin
        last_en_cycles = en_cycles;
        last_residue = frame_residue();
      end
      idle_run++;
    end
    prev_en = en;
  end

  task automatic make_payload(input int len, input int kind, output logic [7:0] p[$]);
    p.delete();
    for (int i = 0; i < len; i++) begin
      if (kind == 0)      p.push_back(8'(i));
      else if (kind == 1) p.push_back(8'hAA);
      else                p.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic push_exp(input logic [7:0] p[$], input int stop_at);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    if (stop_at != 0) begin
      for (int i = 0; i < stop_at; i++) exp_q.push_back({1'b0, p[i]});
      exp_q.push_back({1'b1, 8'h00});
    end else begin
      for (int i = 0; i < p.size(); i++) begin
        exp_q.push_back({1'b0, p[i]});
        c = crc_byte(c, p[i]);
      end
      for (int i = p.size(); i < 60; i++) begin
        exp_q.push_back({1'b0, 8'h00});
        c = crc_byte(c, 8'h00);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
    end
  endtask

  // Entered just after a rising edge; stop_at>0 drops valid (or pulls reset) after that many accepts.
  task automatic send(input logic [7:0] p[$], input int stop_at, input bit do_reset, output int vcyc);
    int i = 0;
    int guard = 0;
    bit acc;
    vcyc = cyc;
    while (i < p.size() && (stop_at == 0 || i < stop_at)) begin
      valid = 1'b1;
      data = p[i];
      last = (i == p.size() - 1);
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
      if (guard > 5000) begin
        check("send_timeout", 64'(i), 64'(p.size()));
        break;
      end
    end
    if (stop_at != 0) begin
      valid = 1'b0;
      last = 1'b0;
      data = 8'h00;
      if (do_reset) rst_n = 1'b0;
      else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic finish_frames();
    int guard = 0;
    valid = 1'b0;
    last = 1'b0;
    data = 8'h00;
    @(negedge clk);
    while (busy && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check("idle_timeout", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  vec_t       vecs[6];
  logic [7:0] p1[$], p2[$];
  int         vcyc, u0;

  initial begin
    vecs[0] = '{64, 0, 76, 0};
    vecs[1] = '{1,  0, 72, 0};
    vecs[2] = '{59, 0, 72, 0};
    vecs[3] = '{60, 0, 72, 0};
    vecs[4] = '{61, 0, 73, 0};
    vecs[5] = '{30, 10, 19, 1};

    repeat (3) @(negedge clk);
    check("reset_outputs", {58'd0, en, er, ready, busy, unr, |txd}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      make_payload(vecs[v].len, (v < 2) ? v : 2, p1);
      push_exp(p1, vecs[v].stop_at);
      u0 = unr_cnt;
      send(p1, vecs[v].stop_at, 1'b0, vcyc);
      finish_frames();
      check($sformatf("v%0d_tx_en_cycles", v), 64'(last_en_cycles), 64'(vecs[v].exp_en));
      check($sformatf("v%0d_scoreboard_empty", v), 64'(exp_q.size()), 64'd0);
      check($sformatf("v%0d_underrun_pulses", v), 64'(unr_cnt - u0), 64'(vecs[v].exp_unr));
      if (vecs[v].stop_at == 0)
        check($sformatf("v%0d_fcs_residue", v), 64'(last_residue), 64'hC704DD7B);
      if (v == 0) check("first_preamble_latency", 64'(rise_cyc - vcyc), 64'd2);
      exp_q.delete();
    end

    // Back-to-back: second frame's valid held through the IFG.
    make_payload(20, 2, p1);
    make_payload(5, 2, p2);
    push_exp(p1, 0);
    push_exp(p2, 0);
    send(p1, 0, 1'b0, vcyc);
    send(p2, 0, 1'b0, vcyc);
    finish_frames();
    check("b2b_gap", 64'(last_gap), 64'd12);
    check("b2b_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("b2b_fcs_residue", 64'(last_residue), 64'hC704DD7B);
    exp_q.delete();

    // Underrun followed immediately by a clean frame.
    make_payload(30, 2, p1);
    make_payload(8, 2, p2);
    push_exp(p1, 10);
    push_exp(p2, 0);
    u0 = unr_cnt;
    send(p1, 10, 1'b0, vcyc);
    send(p2, 0, 1'b0, vcyc);
    finish_frames();
    check("unr_pulses", 64'(unr_cnt - u0), 64'd1);
    check("unr_gap", 64'(last_gap), 64'd12);
    check("unr_next_clean_len", 64'(last_en_cycles), 64'd72);
    check("unr_next_residue", 64'(last_residue), 64'hC704DD7B);
    check("unr_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Asynchronous reset in the middle of the payload.
    make_payload(40, 2, p1);
    push_exp(p1, 0);
    send(p1, 20, 1'b1, vcyc);
    #1;
    check("midframe_reset_outputs", {58'd0, en, er, ready, busy, unr, |txd}, 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    make_payload(60, 2, p1);
    push_exp(p1, 0);
    send(p1, 0, 1'b0, vcyc);
    finish_frames();
    check("post_reset_len", 64'(last_en_cycles), 64'd72);
    check("post_reset_residue", 64'(last_residue), 64'hC704DD7B);
    check("post_reset_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // A few random-length frames.
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(1, 300);
      make_payload(len, 2, p1);
      push_exp(p1, 0);
      send(p1, 0, 1'b0, vcyc);
      finish_frames();
      check($sformatf("rnd%0d_len", r), 64'(last_en_cycles), 64'(12 + ((len < 60) ? 60 : len)));
      check($sformatf("rnd%0d_residue", r), 64'(last_residue), 64'hC704DD7B);
      check($sformatf("rnd%0d_scoreboard_empty", r), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end

    check("ready_only_while_tx_en", 64'(bad_ready), 64'd0);
    check("idle_lines_quiet", 64'(bad_idle), 64'd0);
    check("underrun_matches_tx_er", 64'(bad_unr), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
